// File: rtl/xlr8_pinshare_pkg.sv
// Shared types and constants for the analog pin-share arbiter.
package xlr8_pinshare_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_I2C_OWN = 3'd1,
    ST_ISOLATE = 3'd2,
    ST_ADC_OWN = 3'd3,
    ST_RESTORE = 3'd4
  } pinshare_state_t;

  typedef enum logic {
    OWN_I2C = 1'b0,
    OWN_ADC = 1'b1
  } owner_t;

  // Highest ADC channel that maps onto a physical pin (A0-A5)
  localparam logic [2:0] ADC_PIN_CH_MAX = 3'd5;
  // Analog pins shared with the I2C bus
  localparam logic [2:0] I2C_SDA_CH     = 3'd4;
  localparam logic [2:0] I2C_SCL_CH     = 3'd5;

  // Digital-side isolation bits for a channel; internal channels touch no pin
  function automatic logic [5:0] iso_bits(input logic [2:0] ch, input logic [5:0] mask);
    logic [5:0] sel;
    sel = 6'd0;
    if (ch <= ADC_PIN_CH_MAX) sel = 6'd1 << ch;
    return sel & mask;
  endfunction

  // True when sampling this channel requires the I2C pullups to be off
  function automatic logic is_i2c_pin(input logic [2:0] ch);
    return (ch == I2C_SDA_CH) || (ch == I2C_SCL_CH);
  endfunction

endpackage

// File: rtl/xlr8_pinshare_timer.sv
// Loadable 16-bit down-counter; stops at zero and flags it.
// Shared between settle waits and the grant timeout.
module xlr8_pinshare_timer (
  input  logic        Clock,
  input  logic        RESET_N,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] count;

  // Load takes priority; otherwise count down and hold at zero
  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/xlr8_pinshare_arb.sv
// Arbiter owning the shared analog pin controls (I2C pullups, DIG_IO_OE
// isolation) between one ADC converter and one I2C master.
// Handshake: each req is a level held for the whole transaction; the matching
// gnt is a registered level that rises at least one cycle after req is seen and
// falls on release, done, or timeout. There is no preemption.
module xlr8_pinshare_arb
  import xlr8_pinshare_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES  = 16'd16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
  parameter logic [5:0]  ISO_MASK       = 6'h3F
) (
  input  logic       Clock,
  input  logic       RESET_N,
  input  logic       i2c_req,
  output logic       i2c_gnt,
  input  logic       adc_req,
  input  logic [2:0] adc_ch,
  output logic       adc_gnt,
  input  logic       adc_done,
  output logic       i2c_enable,
  output logic [5:0] dig_io_disc,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  localparam logic        SETTLE_EN    = (SETTLE_CYCLES != 16'd0);
  localparam logic        TMO_EN       = (TIMEOUT_CYCLES != 16'd0);
  localparam logic [15:0] SETTLE_LOAD  = SETTLE_EN ? (SETTLE_CYCLES - 16'd1) : 16'd0;
  localparam logic [15:0] TIMEOUT_LOAD = TMO_EN ? (TIMEOUT_CYCLES - 16'd1) : 16'd0;

  pinshare_state_t state;
  owner_t          last_owner;
  logic [2:0]      ch_q;
  logic            i2c_mask;
  logic            adc_mask;

  logic            tmr_load;
  logic [15:0]     tmr_val;
  logic            tmr_zero;

  logic i2c_pend, adc_pend, pick_adc;
  logic go_i2c, go_adc, adc_pin, q_pin, tmo;
  logic iso_abort, iso_done;
  logic i2c_rel, i2c_tmo, adc_norm, adc_rel, adc_tmo;

  assign state_dbg = state;

  // Arbitration and per-state exit conditions
  always_comb begin
    i2c_pend  = i2c_req & ~i2c_mask;
    adc_pend  = adc_req & ~adc_mask;
    pick_adc  = adc_pend & (~i2c_pend | (last_owner == OWN_I2C));
    go_i2c    = (state == ST_IDLE) & i2c_pend & ~pick_adc;
    go_adc    = (state == ST_IDLE) & pick_adc;
    adc_pin   = (adc_ch <= ADC_PIN_CH_MAX);
    q_pin     = (ch_q <= ADC_PIN_CH_MAX);
    tmo       = TMO_EN & tmr_zero;
    iso_abort = (state == ST_ISOLATE) & ~adc_req;
    iso_done  = (state == ST_ISOLATE) & adc_req & tmr_zero;
    i2c_rel   = (state == ST_I2C_OWN) & (~i2c_req | tmo);
    i2c_tmo   = (state == ST_I2C_OWN) & i2c_req & tmo;
    adc_norm  = adc_done | ~adc_req;
    adc_rel   = (state == ST_ADC_OWN) & (adc_norm | tmo);
    adc_tmo   = (state == ST_ADC_OWN) & ~adc_norm & tmo;
  end

  // Reload the shared timer on every entry into a timed state
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TIMEOUT_LOAD;
    if (go_i2c) begin
      tmr_load = 1'b1;
      tmr_val  = TIMEOUT_LOAD;
    end else if (go_adc) begin
      tmr_load = 1'b1;
      tmr_val  = (adc_pin && SETTLE_EN) ? SETTLE_LOAD : TIMEOUT_LOAD;
    end else if (iso_abort) begin
      tmr_load = 1'b1;
      tmr_val  = SETTLE_LOAD;
    end else if (iso_done) begin
      tmr_load = 1'b1;
      tmr_val  = TIMEOUT_LOAD;
    end else if (adc_rel && q_pin) begin
      tmr_load = 1'b1;
      tmr_val  = SETTLE_LOAD;
    end
  end

  xlr8_pinshare_timer u_timer (
    .Clock    (Clock),
    .RESET_N  (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Ownership FSM with registered grants and pin controls
  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      last_owner  <= OWN_I2C;
      ch_q        <= 3'd0;
      i2c_mask    <= 1'b0;
      adc_mask    <= 1'b0;
      i2c_gnt     <= 1'b0;
      adc_gnt     <= 1'b0;
      i2c_enable  <= 1'b1;
      dig_io_disc <= 6'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (!i2c_req) i2c_mask <= 1'b0;
      if (!adc_req) adc_mask <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (go_i2c) begin
            state   <= ST_I2C_OWN;
            i2c_gnt <= 1'b1;
            busy    <= 1'b1;
          end else if (go_adc) begin
            ch_q <= adc_ch;
            busy <= 1'b1;
            if (adc_pin) begin
              dig_io_disc <= iso_bits(adc_ch, ISO_MASK);
              i2c_enable  <= ~is_i2c_pin(adc_ch);
              if (SETTLE_EN) begin
                state <= ST_ISOLATE;
              end else begin
                state   <= ST_ADC_OWN;
                adc_gnt <= 1'b1;
              end
            end else begin
              state   <= ST_ADC_OWN;
              adc_gnt <= 1'b1;
            end
          end
        end

        ST_I2C_OWN: begin
          if (i2c_rel) begin
            state      <= ST_IDLE;
            i2c_gnt    <= 1'b0;
            last_owner <= OWN_I2C;
            busy       <= 1'b0;
            if (i2c_tmo) begin
              timeout_err <= 1'b1;
              i2c_mask    <= 1'b1;
            end
          end
        end

        ST_ISOLATE: begin
          if (iso_abort) begin
            state       <= ST_RESTORE;
            dig_io_disc <= 6'd0;
            i2c_enable  <= 1'b1;
          end else if (iso_done) begin
            state   <= ST_ADC_OWN;
            adc_gnt <= 1'b1;
          end
        end

        ST_ADC_OWN: begin
          if (adc_rel) begin
            adc_gnt    <= 1'b0;
            last_owner <= OWN_ADC;
            if (adc_tmo) begin
              timeout_err <= 1'b1;
              adc_mask    <= 1'b1;
            end
            if (q_pin) begin
              dig_io_disc <= 6'd0;
              i2c_enable  <= 1'b1;
            end
            if (q_pin && SETTLE_EN) begin
              state <= ST_RESTORE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_RESTORE: begin
          if (tmr_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
